// File: rtl/siso_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB-first, optional parity, stop bit.
// Completed words are presented on a valid/ready holding register with parity, frame and overrun status.
module siso_frame_rx #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_bit_q, par_bit_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                valid_q, valid_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                ovr_q, ovr_d;
    logic                busy_q, busy_d;
    logic                commit;
    logic                calc_perr;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        out_d     = out_q;
        valid_d   = valid_q;
        perr_d    = perr_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        commit    = 1'b0;
        // Received parity bit XOR data XOR mode: nonzero means the bit disagrees with the expected one.
        calc_perr = (PARITY_EN != 0) ? (par_bit_q ^ (^shift_q) ^ (PARITY_ODD != 0)) : 1'b0;

        case (state_q)
            IDLE: begin
                if (serial_in) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            DATA: begin
                shift_d[cnt_q] = serial_in;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                par_bit_d = serial_in;
                state_d   = STOP;
            end
            STOP: begin
                state_d = IDLE;
                if (serial_in) begin
                    ferr_d = 1'b1;
                end else begin
                    commit = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end
        // A full register that is not being drained on this edge keeps its word; the new one is lost.
        if (commit) begin
            if (!valid_q || data_ready) begin
                out_d   = shift_q;
                valid_d = 1'b1;
                perr_d  = calc_perr;
            end else begin
                ovr_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
        end
    end

    assign data_out   = out_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_siso_frame_rx.sv
// Bench for siso_frame_rx (8 data bits, even parity): directed frames plus random traffic,
// checked every cycle against a frame-level model of the holding register and status pulses.
module tb_siso_frame_rx;

    logic       clk;
    logic       reset;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_ovr;
    logic       exp_busy;

    siso_frame_rx #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic pick(input int mode);
        if (mode == 2) return logic'($urandom_range(0, 1));
        return (mode != 0);
    endfunction

    task automatic check_outputs();
        check("data_valid", data_valid, exp_valid);
        if (exp_valid) begin
            check("data_out", data_out, exp_data);
            check("parity_err", parity_err, exp_perr);
        end
        check("frame_err", frame_err, exp_ferr);
        check("overrun", overrun, exp_ovr);
        check("busy", busy, exp_busy);
    endtask

    // One clock: drive a bit, let the edge happen, advance the model, compare.
    task automatic step(input logic b, input logic rdy, input logic in_frame,
                        input logic commit, input logic [7:0] w, input logic pe, input logic fe);
        serial_in  = b;
        data_ready = rdy;
        @(posedge clk);
        exp_ovr  = 1'b0;
        exp_ferr = fe;
        if (commit) begin
            if (!exp_valid || rdy) begin
                exp_valid = 1'b1;
                exp_data  = w;
                exp_perr  = pe;
            end else begin
                exp_ovr = 1'b1;
            end
        end else if (exp_valid && rdy) begin
            exp_valid = 1'b0;
        end
        exp_busy = in_frame;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n, input int rdy_mode);
        for (int i = 0; i < n; i++) step(1'b0, pick(rdy_mode), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // bad_par flips the parity bit; bad_stop sends a 1 as the stop bit.
    task automatic send_frame(input logic [7:0] w, input logic bad_par, input logic bad_stop,
                              input int rdy_body, input int rdy_stop);
        logic pbit;
        pbit = (^w) ^ bad_par;
        step(1'b1, pick(rdy_body), 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(w[i], pick(rdy_body), 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(pbit, pick(rdy_body), 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(bad_stop, pick(rdy_stop), 1'b0, !bad_stop, w, bad_par, bad_stop);
        $display("frame %02h bad_par=%0d bad_stop=%0d valid=%0d data_out=%02h ovr=%0d",
                 w, bad_par, bad_stop, data_valid, data_out, overrun);
    endtask

    task automatic reset_model();
        exp_data  = 8'h00;
        exp_valid = 1'b0;
        exp_perr  = 1'b0;
        exp_ferr  = 1'b0;
        exp_ovr   = 1'b0;
        exp_busy  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_out"}, data_out, 0);
        check({tag, "_data_valid"}, data_valid, 0);
        check({tag, "_parity_err"}, parity_err, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        reset      = 1'b1;
        serial_in  = 1'b0;
        data_ready = 1'b0;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        #2 reset = 1'b0;

        // Clean even-parity frame, consumer always ready: one-cycle valid.
        idle(2, 1);
        send_frame(8'hA5, 1'b0, 1'b0, 1, 1);
        idle(2, 1);

        // Parity error still delivers the word.
        send_frame(8'h01, 1'b1, 1'b0, 1, 0);
        idle(1, 0);
        idle(1, 1);

        // Bad stop bit: frame discarded, frame_err pulse, back to idle.
        send_frame(8'h3C, 1'b0, 1'b1, 1, 1);
        idle(2, 1);

        // Back-to-back with consumer stalled: second word overruns.
        send_frame(8'h11, 1'b0, 1'b0, 0, 0);
        send_frame(8'h22, 1'b0, 1'b0, 0, 0);
        idle(1, 0);
        idle(2, 1);

        // Consume and commit on the same edge.
        send_frame(8'h11, 1'b0, 1'b0, 0, 0);
        send_frame(8'h22, 1'b0, 1'b0, 0, 1);
        idle(1, 0);
        idle(1, 1);

        // Asynchronous reset in the middle of a frame, after four data bits.
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(logic'(i % 2), 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_all_zero("midreset");
        reset_model();
        serial_in = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0, 0, 0);
        idle(1, 1);

        // Random traffic with random gaps, consumer stalls and faults.
        for (int f = 0; f < 40; f++) begin
            send_frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), 2, 2);
            idle($urandom_range(0, 2), 2);
        end
        idle(3, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/siso_frame_rx.md
Name: siso_frame_rx

Overview:
- Frame receiver that sits directly downstream of the serial-in/serial-out shift register and consumes its serial_out stream, one bit per clock.
- Detects a start bit, then collects DATA_W data bits LSB-first, an optional parity bit and a stop bit.
- Presents each completed word on a parallel valid/ready interface, with parity-error, frame-error and overrun status.

Parameters:
- DATA_W, 8: data bits per frame (2..32).
- PARITY_EN, 1: 1 = a parity bit follows the data bits; 0 = no parity bit.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Ignored when PARITY_EN = 0.

Ports:
- clk, input, 1: single clock; every action occurs on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- serial_in, input, 1: serial bit stream, sampled once per rising clk edge. Idle level is 0.
- data_out, output, DATA_W: received word, held stable while data_valid = 1.
- data_valid, output, 1: data_out holds an unconsumed word.
- data_ready, input, 1: consumer accepts the word on any edge where data_valid = 1 and data_ready = 1.
- parity_err, output, 1: parity status of the word on data_out, qualified by data_valid.
- frame_err, output, 1: one-cycle pulse when a stop bit is bad; the frame is discarded.
- overrun, output, 1: one-cycle pulse when a completed word is dropped because the holding register is full.
- busy, output, 1: 1 in every state except IDLE.

Behaviour:
- Reset:
  - Reset is asynchronous, active-high, and overrides everything, including mid-frame.
  - While reset = 1: FSM goes to IDLE; data_out = 0, data_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0.
  - Any partially received frame is discarded.
- Frame format, one bit per clk: start bit (1), then DATA_W data bits LSB-first, then the parity bit if PARITY_EN = 1, then the stop bit (0).
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: serial_in = 1 at an edge → DATA, bit counter cleared. serial_in = 0 → stay in IDLE.
  - DATA: shift serial_in into bit position cnt and increment cnt. After bit DATA_W-1 → PARITY if PARITY_EN = 1, else → STOP.
  - PARITY: capture the parity bit → STOP.
  - STOP:
    - serial_in = 0 → frame good, commit the word → IDLE.
    - serial_in = 1 → frame_err pulses in the following cycle, word discarded → IDLE.
    - The bad stop bit is never reinterpreted as a start bit. The earliest next start bit is the edge after the stop edge.
- Parity check:
  - Even mode: expected parity bit = XOR of the data bits.
  - Odd mode: expected parity bit = inverted XOR of the data bits.
  - A mismatch sets parity_err alongside the committed word. The word is still delivered.
- Latency: data_valid rises in the cycle immediately after the stop-bit sampling edge. Frame length is 1 + DATA_W + PARITY_EN + 1 clocks.
- Back-to-back frames: a start bit may be sampled on the edge immediately after the stop edge, with no idle gap required.
- Handshake:
  - data_valid stays high, and data_out and parity_err stay stable, until an edge where data_ready = 1.
  - If no new word commits on that edge, data_valid falls.
  - data_ready while data_valid = 0 has no effect.
- Commit rules:
  - Holding register empty: word loads and data_valid goes to 1.
  - Holding register full and data_ready = 1 on the same edge: the old word is consumed, the new word loads, data_valid stays 1.
  - Holding register full and data_ready = 0: the new word is dropped, overrun pulses for 1 cycle, and data_out, data_valid and parity_err are unchanged.
- frame_err and overrun are registered single-cycle pulses, never sticky. Both fall to 0 on the next edge.
- busy is a registered decode of the state (1 in DATA, PARITY, STOP).

Test Plan:
1. Clean even-parity frame. DATA_W = 8, PARITY_EN = 1, PARITY_ODD = 0, data_ready = 1. Drive 1, then 0xA5 LSB-first (1,0,1,0,0,1,0,1), parity 0, stop 0. → data_valid = 1 for exactly 1 cycle, in the cycle after the stop edge, with data_out = 0xA5, parity_err = 0, frame_err = 0.
2. Parity error. Send 0x01 with parity bit 0 (expected 1). → data_out = 0x01, data_valid = 1, parity_err = 1.
3. Frame error. Send 0x3C with correct parity 0, then stop bit 1, then serial_in = 0. → no data_valid, frame_err = 1 for 1 cycle, FSM back in IDLE, busy = 0.
4. Back-to-back frames with data_ready = 0. Send 0x11 then 0x22 with no gap. → data_out = 0x11, data_valid stays 1, overrun pulses once when 0x22 completes. Then raise data_ready → data_valid falls and 0x11 is the only word delivered.
5. Simultaneous accept and commit. 0x11 is held; data_ready = 1 on the same edge that 0x22 commits. → 0x11 consumed, data_out = 0x22, data_valid stays 1, overrun = 0.
6. Reset mid-frame. Assert reset asynchronously, between edges, after 4 data bits. → all outputs 0 immediately. Deassert, then send a full 0x3C frame → data_out = 0x3C, parity_err = 0.
